dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the processor's `mem_*` port: the slave end of the interface the core drives from its EM stage. It decodes each request into a word-addressed RAM or a small MMIO region with a byte TX queue. It returns read data after a fixed latency and asserts `mem_ready` only when the next request can be fully accepted. It sits between the core and the board-level I/O, alongside the instruction memory.

## Interface
- `RAM_SCALE`, 14: RAM holds 2^RAM_SCALE 32-bit words.
- `READ_LATENCY`, 2: cycles from request cycle to `mem_valid`; legal range 1..8.
- `TXQ_DEPTH`, 8: TX FIFO entries; power of two, at least 2.
- `clk  in  1`: clock. One clock domain.
- `rst  in  1`: reset, asynchronous, active-high.
- `mem_addr  in  32`: byte address.
- `mem_oe  in  4`: read lane mask, LSB-justified (0001 byte, 0011 half, 1111 word).
- `mem_wdata  in  32`: store data, LSB-justified.
- `mem_we  in  4`: write lane mask, LSB-justified.
- `mem_rdata  out  32`: load data, right-justified to `mem_addr[1:0]`.
- `mem_valid  out  1`: one-cycle pulse; `mem_rdata` valid.
- `mem_ready  out  1`: a request may be presented next cycle.
- `tx_data  out  8`: FIFO head byte.
- `tx_valid  out  1`: FIFO non-empty.
- `tx_ready  in  1`: consumer accepts the head byte.
- `err  out  1`: sticky protocol-violation flag.

## Operation
- **Request cycle:** any cycle with `|mem_we` or `|mem_oe`.
  - Read: `mem_oe[0] && !mem_we[0]`.
  - Write: `mem_we[0]`. Stores also carry `oe`; `oe` is ignored on writes.
- **Decode:**
  - `mem_addr[31:28]==4'hf` selects MMIO.
  - Anything else selects RAM at word index `mem_addr[2+:RAM_SCALE]`. Upper bits are ignored, so addresses alias.
- **Lane alignment:**
  - Effective mask = `(we << mem_addr[1:0])[3:0]`.
  - Effective data = `wdata << 8*mem_addr[1:0]`.
  - Lanes shifted past bit 3 are dropped silently (misaligned access, no err).
  - Read data = `word >> 8*mem_addr[1:0]`, zero-filled. Sign extension belongs to the core.
- **RAM write:** merges enabled bytes at the end of the request cycle.
- **MMIO map (offset = `mem_addr[3:0]`):**
  - 0x0 write: pushes `wdata[7:0]` into the TX FIFO.
  - 0x0 read: returns 0.
  - 0x4 read: `{30'b0, txq_empty, txq_full}`.
  - 0x4 write: ignored.
  - All other offsets read 0 and ignore writes.
- **Read pipeline:**
  - Read data and valid travel through a `READ_LATENCY`-deep shift register.
  - Only one read is in flight at a time.
  - MMIO status is sampled in the request cycle.
- **`mem_ready` is combinational:**
  - Low when a read is pending, including a read request in the current cycle.
  - Low when `txq_count + push_now - pop_now >= TXQ_DEPTH`.
  - Otherwise high.
- **TX FIFO:**
  - `tx_valid = count != 0`.
  - Pop when `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo `TXQ_DEPTH`.
- **Protocol violation:** a request in a cycle after `mem_ready` was low.
  - The request is dropped: no write, no push, no `mem_valid`.
  - `err` is set to 1 and held until reset.

## Timing
- **Reset values:** `mem_valid=0`, `mem_rdata=0`, `tx_valid=0`, `tx_data` undefined-safe 0, `err=0`, FIFO empty, no read pending. `mem_ready=1` one the cycle reset deasserts.
- **Reset mid-read:** the pending read is discarded and no `mem_valid` follows. RAM contents are not reset.
- **Read at cycle r:**
  - `mem_valid=1` with data at cycle r+`READ_LATENCY`.
  - `mem_ready=0` over cycles r..r+L-1 and high at r+L.
  - The next request is legal at r+L+1.
- **Writes:** no latency visible to the core. Back-to-back writes are sustained every cycle while the FIFO has room.
- **Read after write:** a write at cycle w and a read of the same word at w+1 return the new data.
- **FIFO latency:** a pushed byte appears on `tx_data`/`tx_valid` the cycle after the push.
- **FIFO full:** with the FIFO at `TXQ_DEPTH-1` and a push in the current cycle and no pop, `mem_ready` is low in that same cycle.

## Test plan
- `READ_LATENCY=2`: sw 0xDEADBEEF to 0x100 at cycle 0, lw 0x100 at cycle 1 -> `mem_valid` at cycle 3, rdata=0xDEADBEEF, `mem_ready` low in cycles 1–2.
- sb 0x5A (we=0001) to 0x102, then lw 0x100 -> 0xDE5ABEEF. lh (oe=0011) at 0x102 -> 0x0000DE5A.
- With `tx_ready=0`, write 0x41..0x48 to 0xF0000000 on consecutive cycles -> `mem_ready` low after the 8th push. Status read at 0xF0000004 -> 0x1. Raise `tx_ready` -> bytes 0x41..0x48 appear in order, status returns 0x2 when drained.
- Present a write while `mem_ready` was low in the prior cycle -> RAM unchanged, `err=1` sticky.
- Assert `rst` one cycle after a lw request -> no `mem_valid`. After release, `mem_ready=1` and `err=0`.
- sw at 0x00010100 with `RAM_SCALE=14` -> lw 0x100 returns the same data (aliasing).

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's mem_* port: word RAM plus a small MMIO window
// holding a byte-wide TX queue, with fixed-latency read returns.
module dmem_responder #(
  parameter int RAM_SCALE    = 14,
  parameter int READ_LATENCY = 2,
  parameter int TXQ_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        err
);

  localparam int PW  = $clog2(TXQ_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic                 req;
  logic                 is_rd;
  logic                 is_wr;
  logic                 is_mmio;
  logic                 ready_q;
  logic                 accept;
  logic                 rd_accept;
  logic [1:0]           off;
  logic [RAM_SCALE-1:0] word_idx;
  logic [7:0]           we_wide;
  logic [3:0]           we_eff;
  logic [31:0]          wdata_eff;
  logic [31:0]          rd_word;
  logic                 read_pending;

  logic                 push;
  logic                 pop;
  logic [CW-1:0]        count;
  logic [CW1-1:0]       level_next;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [7:0]           txq [TXQ_DEPTH];

  logic [READ_LATENCY-1:0] vld;
  logic [31:0]             pipe [READ_LATENCY];
  logic [31:0]             ram [2**RAM_SCALE];

  assign req       = (|mem_we) || (|mem_oe);
  assign is_wr     = mem_we[0];
  assign is_rd     = mem_oe[0] && !mem_we[0];
  assign is_mmio   = (mem_addr[31:28] == 4'hf);
  assign off       = mem_addr[1:0];
  assign word_idx  = mem_addr[2 +: RAM_SCALE];
  assign accept    = req && ready_q;
  assign rd_accept = accept && is_rd;

  // Lanes shifted past byte 3 fall off the top: misaligned stores are truncated.
  assign we_wide   = {4'b0000, mem_we} << off;
  assign we_eff    = we_wide[3:0];
  assign wdata_eff = mem_wdata << {off, 3'b000};

  assign pop        = (count != '0) && tx_ready;
  assign push       = accept && is_wr && is_mmio && (mem_addr[3:0] == 4'h0) &&
                      ((count != CW'(TXQ_DEPTH)) || pop);
  assign level_next = {1'b0, count} + CW1'(push) - CW1'(pop);

  // The last pipeline stage is the response itself and no longer blocks the bus.
  always_comb begin
    read_pending = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      read_pending = read_pending | vld[i];
    end
  end

  assign mem_ready = !is_rd && !read_pending && (level_next < CW1'(TXQ_DEPTH));

  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      if (mem_addr[3:0] == 4'h4) begin
        rd_word = {30'b0, count == '0, count == CW'(TXQ_DEPTH)};
      end
    end else begin
      rd_word = ram[word_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      err     <= 1'b0;
    end else begin
      ready_q <= mem_ready;
      if (req && !ready_q) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      vld[0]  <= rd_accept;
      pipe[0] <= rd_accept ? (rd_word >> {off, 3'b000}) : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign mem_valid = vld[READ_LATENCY-1];
  assign mem_rdata = pipe[READ_LATENCY-1];

  // RAM contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (accept && is_wr && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (we_eff[b]) begin
          ram[word_idx][8*b +: 8] <= wdata_eff[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      txq[wr_ptr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? txq[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised scoreboard bench for dmem_responder: a byte-level memory/queue model
// predicts every response; a separate monitor matches read returns against it.
module tb_dmem_responder;

  localparam int L     = 2;
  localparam int DEPTH = 8;
  localparam int SCALE = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_oe = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_we = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        err;

  dmem_responder #(.RAM_SCALE(SCALE), .READ_LATENCY(L), .TXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  ram_m[int];
  logic [7:0]  txq_m[$];
  int          busy_until = -1;
  bit          prev_ready_m = 1'b1;
  bit          err_m = 1'b0;

  function automatic void checkVal(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Byte-granular view of memory: each returned byte is looked up individually.
  function automatic logic [31:0] modelRead(logic [31:0] addr);
    logic [31:0] r;
    int off;
    int base;
    r    = '0;
    off  = int'(addr[1:0]);
    base = int'(addr & ((32'd1 << (SCALE + 2)) - 32'd1)) - off;
    if (addr[31:28] == 4'hf) begin
      if (addr[3:0] == 4'h4) r = {30'b0, txq_m.size() == 0, txq_m.size() == DEPTH};
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (off + k < 4) r[8*k +: 8] = ram_m.exists(base + off + k) ? ram_m[base + off + k] : 8'h00;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input logic [3:0] we, input logic [3:0] oe,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic txr);
    bit req, rd, wr, mmio, accepted, pop, push, exp_ready;
    int off, base;
    exp_t e;
    req      = (we != 0) || (oe != 0);
    rd       = oe[0] && !we[0];
    wr       = we[0];
    mmio     = (addr[31:28] == 4'hf);
    accepted = req && prev_ready_m;
    pop      = (txq_m.size() != 0) && txr;
    push     = accepted && wr && mmio && (addr[3:0] == 4'h0);
    if (accepted && rd) busy_until = cyc + L - 1;
    exp_ready = !rd && (cyc > busy_until) && (txq_m.size() + int'(push) - int'(pop) < DEPTH);

    checkVal("mem_ready", {31'b0, mem_ready}, {31'b0, exp_ready});
    checkVal("tx_valid", {31'b0, tx_valid}, {31'b0, txq_m.size() != 0});
    if (txq_m.size() != 0) checkVal("tx_data", {24'b0, tx_data}, {24'b0, txq_m[0]});
    checkVal("err", {31'b0, err}, {31'b0, err_m});

    if (accepted && rd) begin
      e.due  = cyc + L;
      e.data = modelRead(addr);
      sb_q.push_back(e);
    end
    if (accepted && wr && !mmio) begin
      off  = int'(addr[1:0]);
      base = int'(addr & ((32'd1 << (SCALE + 2)) - 32'd1)) - off;
      for (int i = 0; i < 4; i++) begin
        if (we[i] && off + i < 4) ram_m[base + off + i] = wdata[8*i +: 8];
      end
    end
    if (pop) void'(txq_m.pop_front());
    if (push) txq_m.push_back(wdata[7:0]);
    if (req && !prev_ready_m) err_m = 1'b1;
    prev_ready_m = exp_ready;
  endtask

  task automatic applyStimulus(input logic [3:0] we, input logic [3:0] oe,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic txr);
    @(posedge clk);
    #1;
    mem_we    = we;
    mem_oe    = oe;
    mem_addr  = addr;
    mem_wdata = wdata;
    tx_ready  = txr;
    @(negedge clk);
    checkOutput(we, oe, addr, wdata, txr);
  endtask

  task automatic idle(input int n, input logic txr);
    repeat (n) applyStimulus(4'h0, 4'h0, 32'h0, 32'h0, txr);
  endtask

  task automatic waitReady(input logic txr);
    int guard;
    guard = 0;
    while (!prev_ready_m && guard < 20) begin
      idle(1, txr);
      guard++;
    end
    if (!prev_ready_m) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_ready: model never ready within 20 cycles");
    end
  endtask

  task automatic store(input logic [3:0] mask, input logic [31:0] addr, input logic [31:0] data);
    waitReady(1'b0);
    applyStimulus(mask, mask, addr, data, 1'b0);
  endtask

  task automatic load(input logic [3:0] mask, input logic [31:0] addr);
    waitReady(1'b0);
    applyStimulus(4'h0, mask, addr, 32'h0, 1'b0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_we = '0; mem_oe = '0; mem_addr = '0; mem_wdata = '0; tx_ready = 1'b0;
    sb_q.delete();
    txq_m.delete();
    err_m        = 1'b0;
    busy_until   = -1;
    prev_ready_m = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkVal("reset_mem_valid", {31'b0, mem_valid}, 32'h0);
    checkVal("reset_mem_rdata", mem_rdata, 32'h0);
    checkVal("reset_mem_ready", {31'b0, mem_ready}, 32'h1);
    checkVal("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    checkVal("reset_tx_data", {24'b0, tx_data}, 32'h0);
    checkVal("reset_err", {31'b0, err}, 32'h0);
  endtask

  function automatic logic [3:0] pickMask();
    case ($urandom % 3)
      0:       return 4'h1;
      1:       return 4'h3;
      default: return 4'hf;
    endcase
  endfunction

  function automatic logic [31:0] ramAddr();
    logic [15:0] low;
    low = 16'(16'h0100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3));
    return {4'($urandom_range(0, 14)), 12'($urandom), low};
  endfunction

  // Monitor: matches each mem_valid pulse to the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got rdata 0x%08h, expected no response at cycle %0d", mem_rdata, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkVal("read_latency", cyc, e.due);
          checkVal("rdata", mem_rdata, e.data);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_valid: got none, expected 0x%08h due cycle %0d", sb_q[0].data, sb_q[0].due);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    logic        txr;

    doReset();

    for (int k = 0; k < 16; k++) store(4'hf, 32'h0000_0100 + 32'(4 * k), $urandom);

    store(4'hf, 32'h0000_0100, 32'hDEAD_BEEF);
    load(4'hf, 32'h0000_0100);

    store(4'h1, 32'h0000_0102, 32'h0000_005A);
    load(4'hf, 32'h0000_0100);
    load(4'h3, 32'h0000_0102);

    idle(10, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(4'h1, 4'h1, 32'hF000_0000, 32'(32'h41 + i), 1'b0);
    idle(2, 1'b0);
    idle(10, 1'b1);
    load(4'hf, 32'hF000_0004);

    store(4'hf, 32'h0000_0104, 32'h1122_3344);
    load(4'hf, 32'h0000_0100);
    applyStimulus(4'hf, 4'hf, 32'h0000_0104, 32'hCAFE_F00D, 1'b0);
    load(4'hf, 32'h0000_0104);
    idle(3, 1'b0);

    load(4'hf, 32'h0000_0100);
    doReset();
    idle(2, 1'b0);

    store(4'hf, 32'h0001_0100, 32'h0BAD_F00D);
    load(4'hf, 32'h0000_0100);

    for (int n = 0; n < 400; n++) begin
      txr = 1'($urandom % 2);
      if (!prev_ready_m) begin
        idle(1, txr);
      end else begin
        op = int'($urandom % 10);
        if (op <= 2) begin
          idle(1, txr);
        end else if (op <= 4) begin
          logic [3:0] m;
          m = pickMask();
          applyStimulus(m, 4'hf, ramAddr(), $urandom, txr);
        end else if (op <= 6) begin
          applyStimulus(4'h0, pickMask(), ramAddr(), 32'h0, txr);
        end else if (op == 7) begin
          applyStimulus(4'h1, 4'h1, 32'hF000_0000, $urandom, txr);
        end else if (op == 8) begin
          applyStimulus(4'h0, 4'hf, 32'hF000_0004, 32'h0, txr);
        end else begin
          a = 32'hF000_0000 | 32'($urandom_range(1, 15));
          if ($urandom % 2 == 0) applyStimulus(4'hf, 4'hf, a, $urandom, txr);
          else applyStimulus(4'h0, 4'hf, a, 32'h0, txr);
        end
      end
    end

    idle(12, 1'b1);
    checkVal("pending_reads", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
